inst_axi_bridge: RTL
====================

# inst_axi_bridge

Read-only bridge converting the fetch stage's SRAM-like instruction port (req / addr_ok / data_ok) into a single-beat AXI4 read master. Sits directly upstream of the IF stage, between IF and the AXI interconnect, and supplies IF's `inst_sram_addr_ok`, `inst_sram_data_ok` and instruction word. Returns responses strictly in order and tracks outstanding reads with a credit counter.

## Interface
- `ARID`, 4'd0, constant ID driven on every AR request.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_sram_req`  in  1  IF fetch request; held high, with stable address, until `inst_sram_addr_ok`.
- `inst_sram_addr`  in  32  fetch address (the PC).
- `inst_sram_addr_ok`  out  1  address accepted this cycle.
- `inst_sram_data_ok`  out  1  instruction word valid this cycle.
- `inst_sram_rdata`  out  32  instruction word; meaningful only when `inst_sram_data_ok` is high.
- `arid`  out  4  equals `ARID`.
- `araddr`  out  32  captured fetch address.
- `arlen` / `arsize` / `arburst`  out  8/3/2  constants: 0, 3'b010, 2'b01.
- `arlock` / `arcache` / `arprot`  out  2/4/3  constants: 0.
- `arvalid`  out  1  AR request valid.
- `arready`  in  1  AR accepted by slave.
- `rid`  in  4  ignored; responses are in order.
- `rdata`  in  32  read data.
- `rresp`  in  2  ignored; data is forwarded regardless.
- `rlast`  in  1  always 1 for single-beat reads; ignored for counting.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  tied high.

## Operation
- AR FSM, two states:
  - IDLE: `arvalid`=0. If `inst_sram_req` and `cnt < MAX`, capture `inst_sram_addr` into `araddr` and move to AR_BUSY.
  - AR_BUSY: `arvalid`=1. `araddr` is held stable. On `arready`, return to IDLE.
- `inst_sram_addr_ok` = (state==AR_BUSY) & `arready`. It is combinational, so IF sees it in the same cycle as the AR handshake.
- Credit counter `cnt` (2 bits):
  - +1 on AR handshake; −1 on R handshake (`rvalid` & `rready`); unchanged when both occur in the same cycle.
  - Must never exceed MAX or go below 0. If `rvalid` arrives with `cnt`==0, the beat is forwarded and `cnt` saturates at 0.
- R path is registered:
  - `inst_sram_data_ok` <= `rvalid` & `rready`.
  - `inst_sram_rdata` <= `rdata` on that handshake; otherwise holds its value.
- IF flush behaviour is transparent to the bridge. IF keeps `req` high until `addr_ok` and consumes stale `data_ok`, so the bridge never cancels or drops a request.
- `req` falling while in AR_BUSY is legal. The captured request still completes and its `addr_ok` is still pulsed.

## Timing
- Reset values:
  - `arvalid`=0, `araddr`=0, `inst_sram_addr_ok`=0, `inst_sram_data_ok`=0, `inst_sram_rdata`=0.
  - `cnt`=0, state=IDLE. `rready` is 1 out of reset.
- AR latency: `req` seen in cycle N → `arvalid` in N+1 → `addr_ok` in the first cycle ≥N+1 where `arready`=1.
- R latency: `rvalid` & `rready` in cycle M → `data_ok` high exactly in M+1, for exactly one cycle per beat.
- AR throughput: at most one AR per 2 cycles, because of the mandatory IDLE cycle.
- Credits full (`cnt`==MAX): stay in IDLE and do not capture a new request. Capture resumes in the cycle after the credit-returning R handshake, since `cnt` is registered.
- Reset mid-transaction clears all state. The interconnect shares the same `rst`, so in-flight beats are discarded on both sides.

## Configuration
- `INST_BRIDGE_DUAL_OUTSTANDING_EN` defined: MAX=2. A second AR may issue before the first R returns.
- Not defined: MAX=1. A new AR issues only once `cnt` is back to 0.

## Test plan
- Reset, then `req`=1, `addr`=0x1C000000, `arready`=1 at N+1 → `arvalid`=1 and `addr_ok`=1 at N+1 with `araddr`=0x1C000000; `cnt`=1 at N+2.
- `arready` held 0 for 3 cycles with `req` dropping mid-wait → `arvalid` and `araddr` stable for all 3 cycles; `addr_ok` pulses once on `arready`.
- `rvalid`=1, `rdata`=0x02800C0C at cycle M → `data_ok`=1 and `rdata`=0x02800C0C at M+1; `data_ok`=0 at M+2; `cnt` decremented.
- Credit limit, slave never asserts `rvalid`:
  - Macro undefined: second `req` gets no `arvalid` while `cnt`=1.
  - Macro defined: second AR issues, third does not.
- Simultaneous AR handshake and R handshake with `cnt`=1 → `cnt` stays 1; both `addr_ok` and next-cycle `data_ok` are asserted.
- Assert `rst` while in AR_BUSY with `cnt`=1 → the next cycle has `arvalid`=0, `cnt`=0, and every output at its reset value.

Source files
------------

// File: rtl/inst_axi_bridge_if.sv
// Instruction-fetch bridge bus: IF-side SRAM-like port plus AXI4 AR/R channels.
// The master modport is the bridge; the slave modport is whatever drives IF
// requests and acts as the AXI read slave.
interface inst_axi_bridge_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: converts the IF stage's req/addr_ok/data_ok fetch port into
// single-beat AXI4 reads. Responses return in order; a 2-bit credit counter
// limits outstanding reads.
// Optional feature: define INST_BRIDGE_DUAL_OUTSTANDING_EN to allow two
// outstanding reads (MAX=2); default build allows one (MAX=1).
//
// state   | meaning
// IDLE    | no AR pending; may capture a fetch address if credits allow
// AR_BUSY | arvalid high with captured araddr, waiting for arready
module inst_axi_bridge (
  input logic             clk,
  input logic             rst,
  inst_axi_bridge_if.master bus
);

`ifdef INST_BRIDGE_DUAL_OUTSTANDING_EN
  localparam logic [1:0] MAX = 2'd2;
`else
  localparam logic [1:0] MAX = 2'd1;
`endif
  localparam logic [3:0] ARID = 4'd0;

  typedef enum logic {IDLE, AR_BUSY} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        capture;
  logic        ar_hs;
  logic        r_hs;
  logic [1:0]  cnt;
  logic [31:0] araddr_q;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        unused_r_fields;

  assign ar_hs = (state == AR_BUSY) & bus.arready;
  assign r_hs  = bus.rvalid & bus.rready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: capture when requested and a credit is free; leave on arready.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.inst_sram_req && (cnt < MAX)) begin
          capture   = 1'b1;
          state_nxt = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (bus.arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured fetch address, held stable while arvalid is high.
  always_ff @(posedge clk) begin
    if (rst)          araddr_q <= 32'd0;
    else if (capture) araddr_q <= bus.inst_sram_addr;
  end

  // Credit counter; an R beat with no credit outstanding saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   if (cnt != 2'd0) cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered R path: one data_ok pulse per beat, word held between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      data_ok_q <= r_hs;
      if (r_hs) rdata_q <= bus.rdata;
    end
  end

  assign bus.inst_sram_addr_ok = ar_hs;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;

  assign bus.arid    = ARID;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'd0;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = (state == AR_BUSY);
  assign bus.rready  = 1'b1;

  // rid/rresp/rlast carry no information for an in-order single-beat reader.
  assign unused_r_fields = ^{bus.rid, bus.rresp, bus.rlast};

endmodule
